// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings, slave state type and the size/alignment legality check.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR1, S_ERR2} slv_state_e;
  function automatic logic ahb_legal(input logic [6:0] addr_lo, input logic [2:0] size, input int data_width);
    return ((8 << size) <= data_width) && ((addr_lo & 7'((1 << size) - 1)) == 7'd0);
  endfunction
endpackage

// File: rtl/ahb_wait_timer.sv
// ahb_wait_timer: data-phase wait counter; expire_o flags the increment that would reach TIMEOUT.
module ahb_wait_timer #(
  parameter int TIMEOUT = 6
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic inc_i,
  output logic expire_o
);
  localparam int W = $clog2(TIMEOUT) + 1;
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || load_i) cnt_q <= '0;
    else if (inc_i && cnt_q != W'(TIMEOUT)) cnt_q <= cnt_q + 1'b1;
  end
  assign expire_o = inc_i && (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/ahb_slave_if.sv
// ahb_slave_if: AHB responder bridging transfers to a valid/ready local port; AHB_WSTRB_EN adds byte strobes.
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH   = 32,
  parameter int AHB_DATA_WIDTH   = 32,
  parameter int AHB_WAIT_TIMEOUT = 6
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rst_in,
  input  logic                      ahb_sel_in,
  input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
  input  logic [1:0]                ahb_trans_in,
  input  logic [2:0]                ahb_burst_in,
  input  logic [2:0]                ahb_size_in,
  input  logic                      ahb_write_in,
  input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
  input  logic                      ahb_ready_in,
`ifdef AHB_WSTRB_EN
  input  logic [AHB_DATA_WIDTH/8-1:0] ahb_strb_in,
  output logic [AHB_DATA_WIDTH/8-1:0] other_strb_out,
`endif
  output logic                      ahb_readyout_out,
  output logic                      ahb_resp_out,
  output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
  output logic [AHB_ADDR_WIDTH-1:0] other_addr_out,
  output logic [2:0]                other_burst_out,
  output logic [2:0]                other_size_out,
  output logic                      other_write_out,
  output logic                      other_valid_out,
  output logic [AHB_DATA_WIDTH-1:0] other_wdata_out,
  input  logic                      other_ready_in,
  input  logic [AHB_DATA_WIDTH-1:0] other_rdata_in,
  input  logic                      other_error_in
);
  slv_state_e state_q, state_d;
  logic access, skip, ok, done, lerr, accept, legal, expire;
`ifdef AHB_WSTRB_EN
  // An all-zero strobe write touches no bytes, so it completes without a local request.
  assign skip = other_write_out && (ahb_strb_in == '0);
  assign other_strb_out = access ? ahb_strb_in : '0;
`else
  assign skip = 1'b0;
`endif
  assign access = state_q == S_ACCESS;
  assign ok = other_ready_in && !other_error_in;
  assign done = access && (skip || ok);
  assign lerr = access && !skip && other_ready_in && other_error_in;
  assign accept = (state_q == S_IDLE || done) && ahb_sel_in && ahb_ready_in && ahb_trans_in[1];
  assign legal = ahb_legal(ahb_addr_in[6:0], ahb_size_in, AHB_DATA_WIDTH);
  assign ahb_readyout_out = state_q == S_ERR1 ? 1'b0 : access ? (skip || ok) : 1'b1;
  assign ahb_resp_out = (state_q == S_ERR1 || state_q == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign other_valid_out = access && !skip;
  assign other_wdata_out = ahb_wdata_in;
  ahb_wait_timer #(.TIMEOUT(AHB_WAIT_TIMEOUT)) u_timer (
    .clk_i   (ahb_clk_in),
    .rst_i   (ahb_rst_in),
    .load_i  (accept && legal),
    .inc_i   (access && !skip && !other_ready_in),
    .expire_o(expire)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = accept ? (legal ? S_ACCESS : S_ERR1) : S_IDLE;
      S_ACCESS: state_d = done ? (accept ? (legal ? S_ACCESS : S_ERR1) : S_IDLE) : (lerr || expire) ? S_ERR1 : S_ACCESS;
      S_ERR1:   state_d = S_ERR2;
      default:  state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      state_q         <= S_IDLE;
      ahb_rdata_out   <= '0;
      other_addr_out  <= '0;
      other_burst_out <= '0;
      other_size_out  <= '0;
      other_write_out <= 1'b0;
    end else begin
      state_q <= state_d;
      if (done) ahb_rdata_out <= other_write_out ? '0 : other_rdata_in;
      if (accept) begin
        other_addr_out  <= ahb_addr_in;
        other_burst_out <= ahb_burst_in;
        other_size_out  <= ahb_size_in;
        other_write_out <= ahb_write_in;
      end
    end
  end
endmodule

// File: tb/tb_ahb_slave_if.sv
// tb_ahb_slave_if: directed AHB transfers with a queue-based scoreboard checked by a decoupled monitor.
module tb_ahb_slave_if;
  import ahb_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic sel = 1'b0, write = 1'b0, hready, readyout, resp, ovalid, owrite;
  logic [1:0] trans = HTRANS_IDLE;
  logic [2:0] burst = '0, size = '0, oburst, osize;
  logic [31:0] addr = '0, wdata = '0, rdata, oaddr, owdata, ordata = '0;
  logic ordy = 1'b0, oerr = 1'b0;
`ifdef AHB_WSTRB_EN
  logic [3:0] strb = 4'hF, ostrb;
`endif
  always #5 clk = ~clk;
  assign hready = readyout;

  ahb_slave_if dut (
    .ahb_clk_in(clk), .ahb_rst_in(rst), .ahb_sel_in(sel), .ahb_addr_in(addr),
    .ahb_trans_in(trans), .ahb_burst_in(burst), .ahb_size_in(size), .ahb_write_in(write),
    .ahb_wdata_in(wdata), .ahb_ready_in(hready),
`ifdef AHB_WSTRB_EN
    .ahb_strb_in(strb), .other_strb_out(ostrb),
`endif
    .ahb_readyout_out(readyout), .ahb_resp_out(resp), .ahb_rdata_out(rdata),
    .other_addr_out(oaddr), .other_burst_out(oburst), .other_size_out(osize),
    .other_write_out(owrite), .other_valid_out(ovalid), .other_wdata_out(owdata),
    .other_ready_in(ordy), .other_rdata_in(ordata), .other_error_in(oerr)
  );

  typedef struct {logic err; int waits; logic rd; logic [31:0] rdata;} rsp_t;
  typedef struct {logic [31:0] addr; logic wr; logic [31:0] wdata;} req_t;
  rsp_t rsp_q[$];
  req_t req_q[$];
  rsp_t e;
  req_t r;
  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: local handshakes pop req_q, AHB data-phase completions pop rsp_q.
  logic in_dp = 1'b0, saw_err = 1'b0, chk_rd = 1'b0;
  int waits = 0;
  logic [31:0] exp_rd = '0;
  always @(negedge clk) begin
    if (rst) begin
      in_dp = 1'b0;
      chk_rd = 1'b0;
    end else begin
      if (chk_rd) begin
        check("hrdata", rdata, exp_rd);
        chk_rd = 1'b0;
      end
      if (ovalid && ordy) begin
        if (req_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL local_req: got unexpected request addr %0h expected none", oaddr);
        end else begin
          r = req_q.pop_front();
          check("other_addr", oaddr, r.addr);
          check("other_write", owrite, r.wr);
          if (r.wr) check("other_wdata", owdata, r.wdata);
        end
      end
      if (in_dp) begin
        if (!readyout) begin
          if (resp) saw_err = 1'b1;
          else waits++;
        end else begin
          in_dp = 1'b0;
          if (rsp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL completion: got unexpected completion resp %0b expected none", resp);
          end else begin
            e = rsp_q.pop_front();
            check("hresp", resp, e.err);
            check("err_first_cycle", saw_err, e.err);
            check("wait_cycles", waits, e.waits);
            if (e.rd && !e.err) begin
              chk_rd = 1'b1;
              exp_rd = e.rdata;
            end
          end
        end
      end
      if (readyout && sel && trans[1]) begin
        in_dp = 1'b1;
        waits = 0;
        saw_err = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic aph(input logic [31:0] a, input logic [2:0] sz, input logic w, input logic [1:0] tr, input logic [2:0] b);
    sel = 1'b1; addr = a; size = sz; write = w; trans = tr; burst = b;
  endtask
  task automatic bus_idle();
    sel = 1'b0; trans = HTRANS_IDLE;
  endtask
  task automatic exp_rsp(input logic err, input int w, input logic rd, input logic [31:0] d);
    rsp_q.push_back('{err, w, rd, d});
  endtask
  task automatic exp_req(input logic [31:0] a, input logic wr, input logic [31:0] d);
    req_q.push_back('{a, wr, d});
  endtask
  task automatic reset_checks();
    @(negedge clk);
    check("rst_readyout", readyout, 1);
    check("rst_resp", resp, 0);
    check("rst_rdata", rdata, 0);
    check("rst_valid", ovalid, 0);
    check("rst_addr", oaddr, 0);
    check("rst_write", owrite, 0);
  endtask

  initial begin
    step(); step();
    reset_checks();
    step(); rst = 1'b0;
    // Single zero-wait read
    aph(32'h10, 3'd2, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
    exp_req(32'h10, 1'b0, '0); exp_rsp(1'b0, 0, 1'b1, 32'hA5A5_0001);
    step(); bus_idle(); ordy = 1'b1; ordata = 32'hA5A5_0001;
    step(); ordy = 1'b0; step();
    // Write with two local wait cycles
    aph(32'h20, 3'd2, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
    exp_req(32'h20, 1'b1, 32'hDEAD_BEEF); exp_rsp(1'b0, 2, 1'b0, '0);
    step(); bus_idle(); wdata = 32'hDEAD_BEEF;
    step(); step(); ordy = 1'b1;
    step(); ordy = 1'b0; wdata = '0; step();
    // Illegal size, then illegal alignment
    aph(32'h30, 3'd3, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE); exp_rsp(1'b1, 0, 1'b0, '0);
    step(); bus_idle(); step(); step(); step();
    aph(32'h02, 3'd2, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE); exp_rsp(1'b1, 0, 1'b0, '0);
    step(); bus_idle(); step(); step(); step();
    // Local error on first data cycle
    aph(32'h50, 3'd2, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
    exp_req(32'h50, 1'b0, '0); exp_rsp(1'b1, 1, 1'b1, '0);
    step(); bus_idle(); ordy = 1'b1; oerr = 1'b1;
    step(); ordy = 1'b0; oerr = 1'b0; step(); step(); step();
    // Timeout after six wait cycles; late ready is ignored
    aph(32'h60, 3'd2, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE); exp_rsp(1'b1, 6, 1'b1, '0);
    step(); bus_idle();
    repeat (6) step();
    ordy = 1'b1; ordata = 32'hFFFF_FFFF;
    @(negedge clk); check("timeout_valid_drop", ovalid, 0);
    step(); step(); ordy = 1'b0; step();
    // Zero-wait INCR4 read burst
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aph(32'h40 + 32'(4 * i), 3'd2, 1'b0, i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ, HBURST_INCR4);
      ordata = 32'hB000_0000 + 32'(i - 1);
      exp_req(32'h40 + 32'(4 * i), 1'b0, '0); exp_rsp(1'b0, 0, 1'b1, 32'hB000_0000 + 32'(i));
      step();
    end
    bus_idle(); ordata = 32'hB000_0003;
    step(); ordy = 1'b0; step(); step();
    // BUSY mid-burst gets a zero-wait OKAY with no local request
    ordy = 1'b1;
    aph(32'h80, 3'd2, 1'b0, HTRANS_NONSEQ, HBURST_INCR);
    exp_req(32'h80, 1'b0, '0); exp_rsp(1'b0, 0, 1'b1, 32'hC000_0000);
    step(); aph(32'h84, 3'd2, 1'b0, HTRANS_BUSY, HBURST_INCR); ordata = 32'hC000_0000;
    step(); aph(32'h84, 3'd2, 1'b0, HTRANS_SEQ, HBURST_INCR);
    exp_req(32'h84, 1'b0, '0); exp_rsp(1'b0, 0, 1'b1, 32'hC000_0001);
    @(negedge clk);
    check("busy_readyout", readyout, 1);
    check("busy_resp", resp, 0);
    check("busy_no_req", ovalid, 0);
    step(); bus_idle(); ordata = 32'hC000_0001;
    step(); ordy = 1'b0; step(); step();
    // Reset during ACCESS aborts without completion
    aph(32'h90, 3'd2, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
    step(); bus_idle();
    step(); rst = 1'b1;
    step();
    reset_checks();
    step(); rst = 1'b0;
    step(); step();
    check("rsp_q_drained", rsp_q.size(), 0);
    check("req_q_drained", req_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
